// File: rtl/companion_care_scheduler_if.sv
// Bundles the companion scheduler's button, stat and pulse signals.
// The stimulus side (debouncers/stat bank) is the master; the scheduler is the slave.
interface companion_care_scheduler_if;
  logic [2:0]  req;
  logic [95:0] stat_values;
  logic [2:0]  tick;
  logic [2:0]  refresh;
  logic [1:0]  grant_id;
  logic        busy;
  logic        alive;

  modport master (
    output req, stat_values,
    input  tick, refresh, grant_id, busy, alive
  );

  modport slave (
    input  req, stat_values,
    output tick, refresh, grant_id, busy, alive
  );
endinterface

// File: rtl/companion_care_scheduler.sv
// Companion care scheduler: periodic decay ticks, round-robin care refresh
// arbitration with cooldown, and death detection that freezes everything until reset.
module companion_care_scheduler #(
  parameter int unsigned TICK_PERIOD     = 50000000,
  parameter int unsigned COOLDOWN_CYCLES = 25000000
) (
  input  logic                         clk,
  input  logic                         rst,
  companion_care_scheduler_if.slave    bus
);

  typedef enum logic [1:0] {READY, REFRESH, COOLDOWN, DEAD} state_t;

  localparam logic [31:0] TICK_LAST = 32'(TICK_PERIOD - 1);
  localparam logic [31:0] CD_LOAD   = (COOLDOWN_CYCLES == 0) ? 32'd0 : 32'(COOLDOWN_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_req_q, r_pending, r_tick_due, r_tick;
  logic [1:0]  r_grant_id, r_last_grant;
  logic [31:0] r_prescale, r_cooldown;

  logic [2:0]  w_rise, w_grant_mask, w_tick_issue;
  logic [1:0]  w_cand1, w_cand2, w_pick;
  logic        w_grant, w_wrap, w_dead_now;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt  = r_state;
    w_grant      = 1'b0;
    w_rise       = bus.req & ~r_req_q;
    w_dead_now   = (bus.stat_values == '0) && (r_state != DEAD);
    w_wrap       = (r_prescale == TICK_LAST);

    // Round-robin search starts just after the last granted stat.
    w_cand1 = next_idx(r_last_grant);
    w_cand2 = next_idx(w_cand1);
    if (r_pending[w_cand1])      w_pick = w_cand1;
    else if (r_pending[w_cand2]) w_pick = w_cand2;
    else                         w_pick = r_last_grant;

    unique case (r_state)
      READY: begin
        if (r_pending != 3'b000) begin
          w_state_nxt = REFRESH;
          w_grant     = 1'b1;
        end
      end
      REFRESH:  w_state_nxt = (COOLDOWN_CYCLES == 0) ? READY : COOLDOWN;
      COOLDOWN: if (r_cooldown == 32'd0) w_state_nxt = READY;
      DEAD:     w_state_nxt = DEAD;
      default:  w_state_nxt = READY;
    endcase

    // Death wins over any grant decided this cycle.
    if (w_dead_now) begin
      w_state_nxt = DEAD;
      w_grant     = 1'b0;
    end

    w_grant_mask = w_grant ? (3'b001 << w_pick) : 3'b000;
    // A tick colliding with next cycle's refresh of the same stat waits one cycle.
    w_tick_issue = r_tick_due & ~w_grant_mask;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      r_state      <= READY;
      r_req_q      <= 3'b000;
      r_pending    <= 3'b000;
      r_tick_due   <= 3'b000;
      r_tick       <= 3'b000;
      r_grant_id   <= 2'd0;
      r_last_grant <= 2'd2;
      r_prescale   <= 32'd0;
      r_cooldown   <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_req_q <= bus.req;

      if (w_state_nxt == DEAD) begin
        r_pending  <= 3'b000;
        r_tick_due <= 3'b000;
        r_tick     <= 3'b000;
      end else begin
        r_pending  <= (r_pending & ~w_grant_mask) | w_rise;
        r_tick     <= w_tick_issue;
        r_tick_due <= (r_tick_due & ~w_tick_issue) | {3{w_wrap}};
        r_prescale <= w_wrap ? 32'd0 : r_prescale + 32'd1;
      end

      if (w_grant) begin
        r_grant_id   <= w_pick;
        r_last_grant <= w_pick;
      end

      if (r_state == REFRESH)
        r_cooldown <= CD_LOAD;
      else if (r_state == COOLDOWN && r_cooldown != 32'd0)
        r_cooldown <= r_cooldown - 32'd1;
    end
  end

  assign bus.tick     = r_tick;
  assign bus.refresh  = (r_state == REFRESH) ? (3'b001 << r_grant_id) : 3'b000;
  assign bus.grant_id = r_grant_id;
  assign bus.busy     = (r_state == REFRESH) || (r_state == COOLDOWN);
  assign bus.alive    = (r_state != DEAD);

endmodule

// File: tb/tb_companion_care_scheduler.sv
// Directed bench for companion_care_scheduler with TICK_PERIOD=8, COOLDOWN_CYCLES=4.
// Cycle c counts posedges after the one where reset is released (cycle 0).
module tb_companion_care_scheduler;

  localparam logic [95:0] STATS_OK = {32'd5, 32'd7, 32'd9};

  logic clk;
  logic rst;
  int   total;
  int   bad;

  companion_care_scheduler_if bus ();

  companion_care_scheduler #(
    .TICK_PERIOD     (8),
    .COOLDOWN_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, time=%0t required<200000", $time);
    $fatal(1);
  end

  task automatic do_reset;
    rst             = 1'b1;
    bus.req         = 3'b000;
    bus.stat_values = STATS_OK;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst             = 1'b1;
    bus.req         = 3'b000;
    bus.stat_values = STATS_OK;
    repeat (2) @(negedge clk);
    total++; if (bus.tick !== 3'b000) begin bad++; $display("FAIL reset_tick got=%b exp=000", bus.tick); end
    total++; if (bus.refresh !== 3'b000) begin bad++; $display("FAIL reset_refresh got=%b exp=000", bus.refresh); end
    total++; if (bus.grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant_id got=%0d exp=0", bus.grant_id); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.alive !== 1'b1) begin bad++; $display("FAIL reset_alive got=%b exp=1", bus.alive); end
    rst = 1'b0;
  endtask

  task automatic test_ticks;
    logic [2:0] et;
    do_reset;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      et = (c >= 9 && ((c - 9) % 8) == 0) ? 3'b111 : 3'b000;
      total++; if (bus.tick !== et) begin bad++; $display("FAIL ticks_tick c=%0d got=%b exp=%b", c, bus.tick, et); end
      total++; if (bus.refresh !== 3'b000) begin bad++; $display("FAIL ticks_refresh c=%0d got=%b exp=000", c, bus.refresh); end
      total++; if (bus.alive !== 1'b1) begin bad++; $display("FAIL ticks_alive c=%0d got=%b exp=1", c, bus.alive); end
    end
  endtask

  task automatic test_single;
    logic [2:0] er;
    logic       eb;
    do_reset;
    @(negedge clk);
    bus.req = 3'b010;
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      if (c == 2) bus.req = 3'b000;
      er = (c == 3) ? 3'b010 : 3'b000;
      eb = (c >= 3 && c <= 7);
      total++; if (bus.refresh !== er) begin bad++; $display("FAIL single_refresh c=%0d got=%b exp=%b", c, bus.refresh, er); end
      total++; if (bus.busy !== eb) begin bad++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, bus.busy, eb); end
      if (c >= 3) begin
        total++; if (bus.grant_id !== 2'd1) begin bad++; $display("FAIL single_grant_id c=%0d got=%0d exp=1", c, bus.grant_id); end
      end
    end
  endtask

  task automatic test_all_three;
    logic [2:0] er;
    do_reset;
    @(negedge clk);
    bus.req = 3'b111;
    for (int c = 2; c <= 30; c++) begin
      @(negedge clk);
      er = (c == 3) ? 3'b001 : (c == 9) ? 3'b010 : (c == 15) ? 3'b100 : 3'b000;
      total++; if (bus.refresh !== er) begin bad++; $display("FAIL all3_refresh c=%0d got=%b exp=%b", c, bus.refresh, er); end
    end
    bus.req = 3'b000;
    total++; if (bus.grant_id !== 2'd2) begin bad++; $display("FAIL all3_grant_id got=%0d exp=2", bus.grant_id); end
  endtask

  task automatic test_round_robin;
    logic [2:0] er;
    do_reset;
    @(negedge clk);
    bus.req = 3'b001;
    for (int c = 2; c <= 20; c++) begin
      @(negedge clk);
      if (c == 2) bus.req = 3'b100;
      if (c == 4) bus.req = 3'b001;
      if (c == 5) bus.req = 3'b000;
      er = (c == 3) ? 3'b001 : (c == 9) ? 3'b100 : (c == 15) ? 3'b001 : 3'b000;
      total++; if (bus.refresh !== er) begin bad++; $display("FAIL rr_refresh c=%0d got=%b exp=%b", c, bus.refresh, er); end
      if (c == 10) begin
        total++; if (bus.grant_id !== 2'd2) begin bad++; $display("FAIL rr_grant_2 got=%0d exp=2", bus.grant_id); end
      end
      if (c == 16) begin
        total++; if (bus.grant_id !== 2'd0) begin bad++; $display("FAIL rr_grant_0 got=%0d exp=0", bus.grant_id); end
      end
    end
  endtask

  task automatic test_collision;
    logic [2:0] et;
    logic [2:0] er;
    do_reset;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      if (c == 15) bus.req = 3'b100;
      if (c == 16) bus.req = 3'b000;
      et = (c == 9 || c == 25) ? 3'b111 : (c == 17) ? 3'b011 : (c == 18) ? 3'b100 : 3'b000;
      er = (c == 17) ? 3'b100 : 3'b000;
      total++; if (bus.tick !== et) begin bad++; $display("FAIL coll_tick c=%0d got=%b exp=%b", c, bus.tick, et); end
      total++; if (bus.refresh !== er) begin bad++; $display("FAIL coll_refresh c=%0d got=%b exp=%b", c, bus.refresh, er); end
    end
  endtask

  task automatic test_death;
    logic [2:0] et;
    do_reset;
    @(negedge clk);
    bus.req = 3'b001;
    @(negedge clk);
    bus.req         = 3'b000;
    bus.stat_values = '0;
    total++; if (bus.alive !== 1'b1) begin bad++; $display("FAIL death_alive_before got=%b exp=1", bus.alive); end
    for (int c = 3; c <= 30; c++) begin
      @(negedge clk);
      bus.req = (c % 2 == 0) ? 3'b111 : 3'b000;
      if (c == 20) bus.stat_values = STATS_OK;
      total++; if (bus.alive !== 1'b0) begin bad++; $display("FAIL death_alive c=%0d got=%b exp=0", c, bus.alive); end
      total++; if (bus.refresh !== 3'b000) begin bad++; $display("FAIL death_refresh c=%0d got=%b exp=000", c, bus.refresh); end
      total++; if (bus.tick !== 3'b000) begin bad++; $display("FAIL death_tick c=%0d got=%b exp=000", c, bus.tick); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL death_busy c=%0d got=%b exp=0", c, bus.busy); end
    end
    do_reset;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      et = (c == 9) ? 3'b111 : 3'b000;
      total++; if (bus.alive !== 1'b1) begin bad++; $display("FAIL revive_alive c=%0d got=%b exp=1", c, bus.alive); end
      total++; if (bus.tick !== et) begin bad++; $display("FAIL revive_tick c=%0d got=%b exp=%b", c, bus.tick, et); end
    end
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    rst             = 1'b1;
    bus.req         = 3'b000;
    bus.stat_values = STATS_OK;
    test_reset;
    test_ticks;
    test_single;
    test_all_three;
    test_round_robin;
    test_collision;
    test_death;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
